// File: rtl/snes_pkg.sv
// Shared types and constants for the SNES controller input scanner.
package snes_pkg;

  localparam int NUM_BTNS = 12;

  localparam int BTN_B      = 11;
  localparam int BTN_Y      = 10;
  localparam int BTN_SELECT = 9;
  localparam int BTN_START  = 8;
  localparam int BTN_UP     = 7;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_A      = 3;
  localparam int BTN_X      = 2;
  localparam int BTN_L      = 1;
  localparam int BTN_R      = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    FILTER  = 3'd4
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snes_debounce_bit.sv
// One-button debouncer: the stable state flips only after DEBOUNCE_N
// consecutive differing samples, each sample arriving on an update strobe.
module snes_debounce_bit
  import snes_pkg::*;
#(
  parameter int DEBOUNCE_N = 3
) (
  input  logic clk_166MHz,
  input  logic rst_n,
  input  logic i_sample,
  input  logic i_update,
  output logic o_state,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = cnt_width(DEBOUNCE_N);

  logic [CW-1:0] r_cnt;
  logic          r_state;
  logic          w_toggle;

  assign w_toggle = i_update && (i_sample != r_state) && (r_cnt == CW'(DEBOUNCE_N - 1));

  always_ff @(posedge clk_166MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_state <= 1'b0;
    end else if (i_update) begin
      if (i_sample == r_state) begin
        r_cnt <= '0;
      end else if (w_toggle) begin
        r_state <= ~r_state;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Edge outputs are combinational so the event registers catch them on the same edge.
  assign o_state = r_state;
  assign o_rise  = w_toggle & ~r_state;
  assign o_fall  = w_toggle & r_state;

endmodule

// File: rtl/snes_input_scanner.sv
// Periodic SNES reader poller: start/finish sequencing with timeout, per-button
// debounce, and press/release event bundles delivered over valid/ready.
module snes_input_scanner
  import snes_pkg::*;
#(
  parameter int POLL_CYCLES    = 2767000,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int DEBOUNCE_N     = 3,
  parameter bit RAW_ACTIVE_LOW = 1'b1
) (
  input  logic                clk_166MHz,
  input  logic                rst_n,
  input  logic                enable,
  output logic                snes_start,
  input  logic                snes_finish,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_state,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic                timeout_err,
  output logic [7:0]          err_count,
  output state_t              dbg_state
);

  localparam int PW = cnt_width(POLL_CYCLES);
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 2);

  state_t              r_state;
  logic [PW-1:0]       r_period;
  logic [TW-1:0]       r_to;
  logic                r_start;
  logic                r_timeout;
  logic [7:0]          r_err;
  logic [NUM_BTNS-1:0] r_sample;
  logic [NUM_BTNS-1:0] r_press;
  logic [NUM_BTNS-1:0] r_release;
  logic                r_valid;

  logic                w_update;
  logic                w_accept;
  logic [NUM_BTNS-1:0] w_state;
  logic [NUM_BTNS-1:0] w_rise;
  logic [NUM_BTNS-1:0] w_fall;

  assign w_update = (r_state == FILTER);

  // The period counter free-runs through the whole poll so starts stay on a
  // fixed grid; it parks at its last value if a poll is still in flight.
  always_ff @(posedge clk_166MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
    end else if (!enable) begin
      r_period <= '0;
    end else if (r_period == PERIOD_LAST) begin
      if (r_state == IDLE) r_period <= '0;
    end else begin
      r_period <= r_period + PW'(1);
    end
  end

  always_ff @(posedge clk_166MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_to      <= '0;
      r_start   <= 1'b0;
      r_timeout <= 1'b0;
      r_err     <= 8'd0;
      r_sample  <= '0;
    end else begin
      r_start   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable && (r_period == PERIOD_LAST)) begin
            r_state <= REQ;
            r_start <= 1'b1;
          end
        end
        REQ: begin
          r_to    <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (snes_finish) begin
            r_state <= CAPTURE;
          end else if (r_to == TO_LAST) begin
            // Pulse lands exactly TIMEOUT_CYCLES after the start cycle.
            r_to      <= r_to + TW'(1);
            r_timeout <= 1'b1;
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
            r_state   <= IDLE;
          end else begin
            r_to <= r_to + TW'(1);
          end
        end
        CAPTURE: begin
          r_sample <= RAW_ACTIVE_LOW ? ~btn_raw : btn_raw;
          r_state  <= FILTER;
        end
        FILTER: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    snes_debounce_bit #(
      .DEBOUNCE_N(DEBOUNCE_N)
    ) u_bit (
      .clk_166MHz(clk_166MHz),
      .rst_n     (rst_n),
      .i_sample  (r_sample[g]),
      .i_update  (w_update),
      .o_state   (w_state[g]),
      .o_rise    (w_rise[g]),
      .o_fall    (w_fall[g])
    );
  end

  // Handshake: a bundle transfers on any cycle with evt_valid=1 and evt_ready=1.
  // Until then press/release bits only accumulate (OR); after a transfer they
  // clear, except for bits raised by FILTER on that same edge, which survive
  // and keep evt_valid high. evt_ready has no effect while evt_valid=0.
  assign w_accept = r_valid & evt_ready;

  always_ff @(posedge clk_166MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_press   <= '0;
      r_release <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_press   <= (w_accept ? '0 : r_press) | w_rise;
      r_release <= (w_accept ? '0 : r_release) | w_fall;
      r_valid   <= (r_valid & ~evt_ready) | (|w_rise) | (|w_fall);
    end
  end

  assign snes_start  = r_start;
  assign btn_state   = w_state;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign evt_valid   = r_valid;
  assign timeout_err = r_timeout;
  assign err_count   = r_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_snes_input_scanner.sv
// Bench for snes_input_scanner: directed button patterns through a reader
// model, with event bundles checked by a scoreboard on each transfer.
module tb_snes_input_scanner;
  import snes_pkg::*;

  localparam int POLL = 100;
  localparam int TMO  = 64;

  logic        clk_166MHz = 1'b0;
  logic        rst_n      = 1'b0;
  logic        enable     = 1'b0;
  logic        snes_finish = 1'b0;
  logic        evt_ready  = 1'b0;
  logic [11:0] btn_raw    = 12'hFFF;
  logic        snes_start;
  logic [11:0] btn_state;
  logic [11:0] btn_press;
  logic [11:0] btn_release;
  logic        evt_valid;
  logic        timeout_err;
  logic [7:0]  err_count;
  state_t      dbg_state;

  int          checks = 0;
  int          errors = 0;
  logic [35:0] exp_q[$];
  logic [35:0] exp_bundle;

  logic        reader_on = 1'b1;
  logic [11:0] raw_val   = 12'hFFF;
  int          rd_cnt    = 0;
  int          cyc       = 0;
  int          last_start = -1;
  logic        prev_start = 1'b0;

  // ---------------- clock / reset ----------------
  always #3 clk_166MHz = ~clk_166MHz;
  always @(posedge clk_166MHz) cyc <= cyc + 1;

  snes_input_scanner #(
    .POLL_CYCLES   (POLL),
    .TIMEOUT_CYCLES(TMO),
    .DEBOUNCE_N    (3),
    .RAW_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_166MHz (clk_166MHz),
    .rst_n      (rst_n),
    .enable     (enable),
    .snes_start (snes_start),
    .snes_finish(snes_finish),
    .btn_raw    (btn_raw),
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .timeout_err(timeout_err),
    .err_count  (err_count),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reader model: finish 36 cycles after start, new data presented with it.
  always @(negedge clk_166MHz) begin
    if (rd_cnt > 0) begin
      rd_cnt = rd_cnt - 1;
      if (rd_cnt == 0) begin
        snes_finish = 1'b1;
        btn_raw     = raw_val;
      end
    end else begin
      snes_finish = 1'b0;
    end
    if (snes_start && reader_on && rst_n) rd_cnt = 36;
  end

  // Start watcher: one-cycle width and fixed period while enabled.
  always @(negedge clk_166MHz) begin
    if (!rst_n || !enable) begin
      last_start <= -1;
    end else begin
      if (snes_start) check("start_width", 64'(prev_start), 64'd0);
      if (snes_start && last_start >= 0) check("start_period", 64'(cyc - last_start), 64'(POLL));
      if (snes_start) last_start <= cyc;
    end
    prev_start <= snes_start;
  end

  // Scoreboard monitor: compare {press, release, state} on every transfer.
  always @(negedge clk_166MHz) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL evt_unexpected: got press=%0h release=%0h state=%0h, no event expected",
                 btn_press, btn_release, btn_state);
      end else begin
        exp_bundle = exp_q.pop_front();
        check("evt_bundle", 64'({btn_press, btn_release, btn_state}), 64'(exp_bundle));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_start();
    int n = 0;
    do begin
      @(negedge clk_166MHz);
      n++;
    end while (!snes_start && n < 300);
    if (!snes_start) begin
      checks++;
      errors++;
      $display("FAIL wait_start: got no snes_start within 300 cycles, required one");
    end
  endtask

  task automatic polls(input int k);
    repeat (k) wait_start();
    repeat (45) @(negedge clk_166MHz);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk_166MHz);
    #1 evt_ready = v;
  endtask

  task automatic pulse_ready();
    set_ready(1'b1);
    set_ready(1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk_166MHz);
    check("rst_start",   64'(snes_start),  64'd0);
    check("rst_state",   64'(btn_state),   64'd0);
    check("rst_press",   64'(btn_press),   64'd0);
    check("rst_release", 64'(btn_release), 64'd0);
    check("rst_valid",   64'(evt_valid),   64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    check("rst_errcnt",  64'(err_count),   64'd0);
    check("rst_fsm",     64'(dbg_state),   64'(IDLE));

    rst_n     = 1'b1;
    enable    = 1'b1;
    evt_ready = 1'b1;

    // Idle buttons: no state change, no events.
    raw_val = 12'hFFF;
    polls(3);
    check("basic_state", 64'(btn_state), 64'd0);
    check("basic_valid", 64'(evt_valid), 64'd0);

    // B press under backpressure, debounce boundary after 2 polls.
    set_ready(1'b0);
    raw_val = 12'h7FF;
    polls(2);
    check("deb_2polls_state", 64'(btn_state), 64'd0);
    polls(1);
    check("deb_state",   64'(btn_state),   64'h800);
    check("deb_press",   64'(btn_press),   64'h800);
    check("deb_release", 64'(btn_release), 64'd0);
    check("deb_valid",   64'(evt_valid),   64'd1);
    exp_q.push_back({12'h800, 12'h000, 12'h800});
    pulse_ready();
    @(negedge clk_166MHz);
    check("deb_valid_clr", 64'(evt_valid), 64'd0);
    check("deb_press_clr", 64'(btn_press), 64'd0);

    // B release with ready held high.
    set_ready(1'b1);
    raw_val = 12'hFFF;
    exp_q.push_back({12'h000, 12'h800, 12'h000});
    polls(3);
    check("rel_state", 64'(btn_state), 64'd0);

    // Two-poll glitch must not produce an event.
    raw_val = 12'h7FF;
    polls(2);
    raw_val = 12'hFFF;
    polls(2);
    check("glitch_state", 64'(btn_state), 64'd0);
    check("glitch_valid", 64'(evt_valid), 64'd0);

    // Backpressure merge: B then START accumulate.
    set_ready(1'b0);
    raw_val = 12'h7FF;
    polls(3);
    check("merge1_press", 64'(btn_press), 64'h800);
    check("merge1_valid", 64'(evt_valid), 64'd1);
    raw_val = 12'h6FF;
    polls(3);
    check("merge2_press", 64'(btn_press), 64'h900);
    check("merge2_state", 64'(btn_state), 64'h900);
    check("merge2_valid", 64'(evt_valid), 64'd1);
    exp_q.push_back({12'h900, 12'h000, 12'h900});
    pulse_ready();
    @(negedge clk_166MHz);
    check("merge_valid_clr", 64'(evt_valid), 64'd0);
    check("merge_press_clr", 64'(btn_press), 64'd0);

    set_ready(1'b1);
    raw_val = 12'hFFF;
    exp_q.push_back({12'h000, 12'h900, 12'h000});
    polls(3);

    // Press and release of B both pending.
    set_ready(1'b0);
    raw_val = 12'h7FF;
    polls(3);
    raw_val = 12'hFFF;
    polls(3);
    check("pend_press",   64'(btn_press),   64'h800);
    check("pend_release", 64'(btn_release), 64'h800);
    check("pend_state",   64'(btn_state),   64'd0);
    check("pend_valid",   64'(evt_valid),   64'd1);
    exp_q.push_back({12'h800, 12'h800, 12'h000});
    pulse_ready();
    @(negedge clk_166MHz);
    check("pend_valid_clr", 64'(evt_valid), 64'd0);

    // Timeout: silent reader.
    reader_on = 1'b0;
    wait_start();
    n = 0;
    do begin
      @(negedge clk_166MHz);
      n++;
    end while (!timeout_err && n < 200);
    check("timeout_latency", 64'(n), 64'(TMO));
    check("timeout_cnt1",    64'(err_count), 64'd1);
    @(negedge clk_166MHz);
    check("timeout_pulse_w", 64'(timeout_err), 64'd0);
    repeat (299) wait_start();
    repeat (70) @(negedge clk_166MHz);
    check("timeout_sat",   64'(err_count), 64'd255);
    check("timeout_state", 64'(btn_state), 64'd0);

    // Reset asserted during the start cycle of a poll.
    reader_on = 1'b1;
    set_ready(1'b1);
    raw_val = 12'h7FF;
    exp_q.push_back({12'h800, 12'h000, 12'h800});
    polls(3);
    check("prerst_state", 64'(btn_state), 64'h800);
    wait_start();
    rst_n = 1'b0;
    #1;
    check("mrst_start",   64'(snes_start),  64'd0);
    check("mrst_state",   64'(btn_state),   64'd0);
    check("mrst_press",   64'(btn_press),   64'd0);
    check("mrst_release", 64'(btn_release), 64'd0);
    check("mrst_valid",   64'(evt_valid),   64'd0);
    check("mrst_timeout", 64'(timeout_err), 64'd0);
    check("mrst_errcnt",  64'(err_count),   64'd0);
    repeat (3) @(negedge clk_166MHz);
    rst_n = 1'b1;

    // enable drops mid-WAIT: that poll still completes, then no more starts.
    polls(2);
    wait_start();
    repeat (10) @(negedge clk_166MHz);
    enable = 1'b0;
    exp_q.push_back({12'h800, 12'h000, 12'h800});
    repeat (60) @(negedge clk_166MHz);
    check("dis_state", 64'(btn_state), 64'h800);
    check("dis_fsm",   64'(dbg_state), 64'(IDLE));
    n = 0;
    repeat (300) begin
      @(negedge clk_166MHz);
      if (snes_start) n++;
    end
    check("dis_no_start", 64'(n), 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snes_input_scanner.md
Name: snes_input_scanner

Overview:
- Upstream/downstream companion of the SNES controller serial reader. It periodically issues a one-cycle start request and waits for the reader's finish strobe.
- It then samples the reader's 12 parallel button outputs, debounces each button and produces held state plus press/release event pulses.
- Events go out through a valid/ready handshake to game logic. A reader that never returns finish is caught by a timeout.

Parameters:
- POLL_CYCLES, 2767000: clk_166MHz cycles between poll starts (~60 Hz); minimum 64.
- TIMEOUT_CYCLES, 256: max cycles from start to finish before an error.
- DEBOUNCE_N, 3: consecutive identical samples needed to change a stable button state; range 1..15.
- RAW_ACTIVE_LOW, 1: 1 means a raw bit of 0 means pressed (SNES wire polarity); 0 means no inversion.

Ports:
- clk_166MHz in 1: single clock; everything is synchronous to it.
- rst_n in 1: asynchronous assert, active-low reset.
- enable in 1: 1 lets polling run; 0 lets the current poll finish, then parks in IDLE.
- snes_start out 1: one-cycle start pulse to the reader.
- snes_finish in 1: reader completion strobe, synchronous to clk_166MHz.
- btn_raw in 12: reader outputs. Bit order [11:0] = B,Y,SELECT,START,UP,DOWN,LEFT,RIGHT,A,X,L,R.
- btn_state out 12: debounced held state, 1 = pressed.
- btn_press out 12: accumulated press events.
- btn_release out 12: accumulated release events.
- evt_valid out 1: event bundle pending.
- evt_ready in 1: consumer accepts the bundle.
- timeout_err out 1: one-cycle pulse on each timeout.
- err_count out 8: saturating timeout count.

Behaviour:
- Reset (async, rst_n=0) clears:
  - all outputs: snes_start=0, btn_state=0, btn_press=0, btn_release=0, evt_valid=0, timeout_err=0, err_count=0;
  - state=IDLE, period counter=0, debounce counters=0.
- FSM states: IDLE, REQ, WAIT, CAPTURE, FILTER.
- IDLE:
  - Period counter increments each cycle while enable=1.
  - On reaching POLL_CYCLES-1: counter clears and the FSM moves to REQ.
  - enable=0 holds the counter at 0.
- REQ: snes_start=1 for exactly this one cycle; next state is WAIT, with the timeout counter cleared.
- WAIT:
  - snes_finish=1 → CAPTURE. The reader's outputs update on finish, so raw data is sampled one cycle later.
  - Timeout counter reaches TIMEOUT_CYCLES-1 first → timeout_err pulses 1 cycle, err_count increments (saturates at 255), return to IDLE. Debounce and events are untouched.
  - snes_finish outside WAIT is ignored.
- CAPTURE: register btn_raw into a sample register (inverted if RAW_ACTIVE_LOW=1) → FILTER.
- FILTER: per bit i, in one cycle:
  - Sample equals btn_state[i]: counter_i=0.
  - Sample differs and counter_i=DEBOUNCE_N-1: btn_state[i] toggles and counter_i=0. A 0→1 toggle sets btn_press[i]; a 1→0 toggle sets btn_release[i].
  - Otherwise counter_i increments.
  - If any event bit was set this cycle, evt_valid=1. Next state is IDLE.
- Worst-case latency from a stable physical change to btn_state is DEBOUNCE_N polls.
- Handshake:
  - Transfer occurs on a cycle with evt_valid=1 and evt_ready=1. On the next cycle the press/release registers clear and evt_valid drops, unless FILTER adds new bits that same cycle; those new bits survive and keep evt_valid=1.
  - While evt_valid=1 and not accepted, new events OR into btn_press/btn_release; none are lost.
  - A press and release of the same bit may both be pending.
  - btn_press, btn_release and evt_valid are stable while valid and not ready, except for that OR-accumulation.
  - evt_ready is ignored while evt_valid=0.
- enable falling during REQ, WAIT, CAPTURE or FILTER: the sequence completes and the FSM then stays in IDLE.
- rst_n asserted mid-poll: immediate return to reset values; snes_start drops asynchronously.
- POLL_CYCLES sizes the period counter width via clog2. TIMEOUT_CYCLES and DEBOUNCE_N size their counters the same way.

Decomposition:
- Shared package snes_pkg:
  - state enum (IDLE, REQ, WAIT, CAPTURE, FILTER);
  - button index constants BTN_B=11 … BTN_R=0;
  - NUM_BTNS=12.
- Sub-module snes_debounce_bit: one counter plus stable state; inputs sample, update strobe; outputs state, rise, fall. Instantiated 12 times via generate.

Test Plan (POLL_CYCLES=100, TIMEOUT_CYCLES=64, DEBOUNCE_N=3, RAW_ACTIVE_LOW=1):
- Basic poll: reset release, enable=1, reader model returns finish 36 cycles after start with btn_raw=12'hFFF → snes_start pulses every 100 cycles, one cycle wide; btn_state stays 0; evt_valid never asserts.
- Debounce press: btn_raw=12'h7FF (B pressed) for 3 polls → after the 3rd FILTER, btn_state=12'h800, btn_press=12'h800, evt_valid=1. A 2-poll glitch followed by a return to 12'hFFF produces no event.
- Backpressure merge: evt_ready=0 while B presses, then later START (bit 8) presses → btn_press=12'h900, evt_valid held. Setting evt_ready=1 for one cycle clears it next cycle.
- Press and release pending: B pressed, then released (stable 3 polls) with evt_ready=0 → btn_press=12'h800, btn_release=12'h800, btn_state=0.
- Timeout: reader never asserts finish → timeout_err pulses 64 cycles after start, err_count=1, next start on schedule. After 300 consecutive timeouts, err_count=255.
- Reset/enable: rst_n=0 during WAIT → all outputs 0 immediately. enable=0 during WAIT with finish at cycle 36 → capture completes, no further snes_start.
